// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: turns button presses into single-step moves on a bounded grid
// with a step budget, decodes position status and runs the exit timer.
// Ports:
//   clk_50MHz_i, rst_async_la_i        clock, asynchronous active-low reset
//   btn_up/down/left/right_i           asynchronous active-high buttons
//   freeze_i                           ignore all moves while high
//   enable_count_last_i                exit timer enable
//   pos_x_o, pos_y_o, steps_left_o     current position and remaining steps
//   move_ack_o, bump_o                 one-cycle accept / edge-reject pulses
//   in_key_pos_o, in_exit_pos_o        position matches key / exit cell
//   out_of_steps_o, timeout_15s_o      step budget exhausted, exit timer expired
module maze_move_ctrl #(
    parameter int GRID_W         = 8,
    parameter int GRID_H         = 8,
    parameter int MAX_STEPS      = 32,
    parameter int START_X        = 0,
    parameter int START_Y        = 0,
    parameter int KEY_X          = 5,
    parameter int KEY_Y          = 2,
    parameter int EXIT_X         = 7,
    parameter int EXIT_Y         = 7,
    parameter int TIMEOUT_CYCLES = 750000000,
    localparam int XW            = $clog2(GRID_W),
    localparam int YW            = $clog2(GRID_H),
    localparam int SW            = $clog2(MAX_STEPS + 1)
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_async_la_i,
    input  logic          btn_up_i,
    input  logic          btn_down_i,
    input  logic          btn_left_i,
    input  logic          btn_right_i,
    input  logic          freeze_i,
    input  logic          enable_count_last_i,
    output logic [XW-1:0] pos_x_o,
    output logic [YW-1:0] pos_y_o,
    output logic [SW-1:0] steps_left_o,
    output logic          move_ack_o,
    output logic          bump_o,
    output logic          in_key_pos_o,
    output logic          in_exit_pos_o,
    output logic          out_of_steps_o,
    output logic          timeout_15s_o
);
    logic [3:0]    btn, sync1, sync2, sync3, rise;
    logic [2:0]    prime;
    logic [29:0]   cnt;
    logic          take, at_edge;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    // bit order sets priority: up > down > left > right
    assign btn = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
    // edges are only trusted once sync3 holds a real sample, so buttons held
    // through reset never look like a fresh press
    assign rise = prime[2] ? (sync2 & ~sync3) : 4'd0;

    always_comb begin
        at_edge = rise[3] ? (pos_y_o == '0) :
                  rise[2] ? (pos_y_o == YW'(GRID_H - 1)) :
                  rise[1] ? (pos_x_o == '0) :
                            (pos_x_o == XW'(GRID_W - 1));
        nx      = (rise[3] | rise[2]) ? pos_x_o :
                  rise[1] ? pos_x_o - 1'b1 : pos_x_o + 1'b1;
        ny      = rise[3] ? pos_y_o - 1'b1 :
                  rise[2] ? pos_y_o + 1'b1 : pos_y_o;
        take    = (|rise) && !freeze_i && (steps_left_o != '0);
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            sync1        <= '0;
            sync2        <= '0;
            sync3        <= '0;
            prime        <= '0;
            pos_x_o      <= XW'(START_X);
            pos_y_o      <= YW'(START_Y);
            steps_left_o <= SW'(MAX_STEPS);
            move_ack_o   <= 1'b0;
            bump_o       <= 1'b0;
        end else begin
            sync1      <= btn;
            sync2      <= sync1;
            sync3      <= sync2;
            prime      <= {prime[1:0], 1'b1};
            move_ack_o <= take && !at_edge;
            bump_o     <= take && at_edge;
            if (take && !at_edge) begin
                pos_x_o      <= nx;
                pos_y_o      <= ny;
                steps_left_o <= steps_left_o - 1'b1;
            end
        end
    end

    // counter holds at the terminal value so the flag stays up until enable drops
    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            cnt           <= '0;
            timeout_15s_o <= 1'b0;
        end else if (!enable_count_last_i) begin
            cnt           <= '0;
            timeout_15s_o <= 1'b0;
        end else if (cnt == 30'(TIMEOUT_CYCLES - 1)) begin
            timeout_15s_o <= 1'b1;
        end else begin
            cnt <= cnt + 30'd1;
        end
    end

    assign in_key_pos_o   = (pos_x_o == XW'(KEY_X)) && (pos_y_o == YW'(KEY_Y));
    assign in_exit_pos_o  = (pos_x_o == XW'(EXIT_X)) && (pos_y_o == YW'(EXIT_Y));
    assign out_of_steps_o = (steps_left_o == '0);
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed bench for maze_move_ctrl (full budget and 3-step instances)
module tb_maze_move_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_a = '0, btn_b = '0;
    logic       freeze = 1'b0, en = 1'b0;

    logic [2:0] a_px, a_py, b_px, b_py;
    logic [5:0] a_steps;
    logic [1:0] b_steps;
    logic a_ack, a_bump, a_key, a_exit, a_oos, a_tmo;
    logic b_ack, b_bump, b_key, b_exit, b_oos, b_tmo;

    int n_chk = 0, n_fail = 0;
    int ex = 0, ey = 0, es = 32;

    always #10 clk = ~clk;

    maze_move_ctrl #(.TIMEOUT_CYCLES(20)) u_a (
        .clk_50MHz_i(clk), .rst_async_la_i(rst),
        .btn_up_i(btn_a[3]), .btn_down_i(btn_a[2]), .btn_left_i(btn_a[1]), .btn_right_i(btn_a[0]),
        .freeze_i(freeze), .enable_count_last_i(en),
        .pos_x_o(a_px), .pos_y_o(a_py), .steps_left_o(a_steps),
        .move_ack_o(a_ack), .bump_o(a_bump), .in_key_pos_o(a_key), .in_exit_pos_o(a_exit),
        .out_of_steps_o(a_oos), .timeout_15s_o(a_tmo)
    );

    maze_move_ctrl #(.MAX_STEPS(3), .TIMEOUT_CYCLES(20)) u_b (
        .clk_50MHz_i(clk), .rst_async_la_i(rst),
        .btn_up_i(btn_b[3]), .btn_down_i(btn_b[2]), .btn_left_i(btn_b[1]), .btn_right_i(btn_b[0]),
        .freeze_i(freeze), .enable_count_last_i(en),
        .pos_x_o(b_px), .pos_y_o(b_py), .steps_left_o(b_steps),
        .move_ack_o(b_ack), .bump_o(b_bump), .in_key_pos_o(b_key), .in_exit_pos_o(b_exit),
        .out_of_steps_o(b_oos), .timeout_15s_o(b_tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        ex = 0; ey = 0; es = 32;
    endtask

    // press on instance a; the expected outcome comes from the grid model ex/ey/es
    task automatic press_a(input string tag, input logic [3:0] b);
        int tx, ty;
        logic acc, bmp;
        tx = ex; ty = ey;
        if (b[3]) ty = ey - 1;
        else if (b[2]) ty = ey + 1;
        else if (b[1]) tx = ex - 1;
        else tx = ex + 1;
        bmp = !freeze && es != 0 && (tx < 0 || tx > 7 || ty < 0 || ty > 7);
        acc = !freeze && es != 0 && !bmp;
        if (acc) begin ex = tx; ey = ty; es--; end
        btn_a = b;
        tick();
        tick();
        chk({tag, "_ack_early"}, a_ack, 0);
        tick();
        chk({tag, "_ack"}, a_ack, acc);
        chk({tag, "_bump"}, a_bump, bmp);
        chk({tag, "_x"}, a_px, ex);
        chk({tag, "_y"}, a_py, ey);
        chk({tag, "_steps"}, a_steps, es);
        chk({tag, "_key"}, a_key, ex == 5 && ey == 2);
        chk({tag, "_exit"}, a_exit, ex == 7 && ey == 7);
        chk({tag, "_oos"}, a_oos, es == 0);
        btn_a = '0;
        tick();
        chk({tag, "_ack_width"}, a_ack, 0);
        chk({tag, "_bump_width"}, a_bump, 0);
        repeat (3) tick();
    endtask

    task automatic press_b(input string tag, input logic exp_ack, input int exp_x, input logic exp_oos);
        btn_b = 4'b0001;
        repeat (3) tick();
        chk({tag, "_ack"}, b_ack, exp_ack);
        chk({tag, "_bump"}, b_bump, 0);
        chk({tag, "_x"}, b_px, exp_x);
        chk({tag, "_oos"}, b_oos, exp_oos);
        btn_b = '0;
        repeat (4) tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_x", a_px, 0);
        chk("rst_y", a_py, 0);
        chk("rst_steps", a_steps, 32);
        chk("rst_steps_b", b_steps, 3);
        chk("rst_ack", a_ack, 0);
        chk("rst_bump", a_bump, 0);
        chk("rst_key", a_key, 0);
        chk("rst_exit", a_exit, 0);
        chk("rst_oos", a_oos, 0);
        chk("rst_tmo", a_tmo, 0);
        rst = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 4; i++) press_a("right", 4'b0001);
        chk("t1_x", a_px, 4);
        chk("t1_steps", a_steps, 28);

        do_reset();
        press_a("left_edge", 4'b0010);
        press_a("up_right", 4'b1001);

        repeat (5) press_a("walk_r", 4'b0001);
        repeat (2) press_a("walk_d", 4'b0100);
        chk("at_key", a_key, 1);
        repeat (2) press_a("walk_r2", 4'b0001);
        repeat (5) press_a("walk_d2", 4'b0100);
        chk("at_exit", a_exit, 1);
        chk("exit_not_key", a_key, 0);
        press_a("right_edge", 4'b0001);
        press_a("down_edge", 4'b0100);

        do_reset();
        press_b("b1", 1, 1, 0);
        press_b("b2", 1, 2, 0);
        press_b("b3", 1, 3, 1);
        chk("b_steps0", b_steps, 0);
        press_b("b4", 0, 3, 1);

        en = 1'b1;
        repeat (19) tick();
        chk("tmo_early", a_tmo, 0);
        tick();
        chk("tmo_rise", a_tmo, 1);
        repeat (5) tick();
        chk("tmo_hold", a_tmo, 1);
        en = 1'b0;
        tick();
        chk("tmo_clear", a_tmo, 0);
        en = 1'b1;
        repeat (10) tick();
        en = 1'b0;
        tick();
        chk("tmo_drop", a_tmo, 0);
        en = 1'b1;
        repeat (19) tick();
        chk("tmo_restart_early", a_tmo, 0);
        tick();
        chk("tmo_restart", a_tmo, 1);

        repeat (2) tick();
        press_a("pre_rst", 4'b0001);
        chk("pre_rst_tmo", a_tmo, 1);
        btn_a = 4'b0001;
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        chk("arst_x", a_px, 0);
        chk("arst_steps", a_steps, 32);
        chk("arst_tmo", a_tmo, 0);
        chk("arst_ack", a_ack, 0);
        chk("arst_b_steps", b_steps, 3);
        en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("held_no_move", a_px, 0);
        chk("held_steps", a_steps, 32);
        btn_a = '0;
        repeat (4) tick();
        ex = 0; ey = 0; es = 32;

        freeze = 1'b1;
        press_a("frz_right", 4'b0001);
        press_a("frz_left", 4'b0010);
        freeze = 1'b0;
        press_a("unfrz_right", 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/maze_move_ctrl.md
# maze_move_ctrl

Player-movement controller for the maze game datapath. It turns four asynchronous direction buttons into single-step moves on a bounded grid and charges each accepted move against a step budget. It produces the position-derived status the game state machine consumes (in_key_pos, in_exit_pos, out_of_steps) and runs the 15 s exit timer gated by enable_count_last. It sits between the board buttons and the game FSM, and also drives the position and step-count displays.

## Interface

Parameters:
- GRID_W, 8: grid columns; x ranges 0..GRID_W-1, width XW = clog2(GRID_W).
- GRID_H, 8: grid rows; y ranges 0..GRID_H-1, width YW = clog2(GRID_H).
- MAX_STEPS, 32: step budget loaded at reset; width SW = clog2(MAX_STEPS+1).
- START_X, START_Y, 0 / 0: position loaded at reset.
- KEY_X, KEY_Y, 5 / 2: key cell.
- EXIT_X, EXIT_Y, 7 / 7: exit cell.
- TIMEOUT_CYCLES, 750000000: exit timer length (15 s at 50 MHz); 30-bit counter.

Ports:
- clk_50MHz_i  in  1  system clock.
- rst_async_la_i  in  1  reset, asynchronous, active-low.
- btn_up_i, btn_down_i, btn_left_i, btn_right_i  in  1 each  debounced but asynchronous buttons, active-high.
- freeze_i  in  1  high = ignore all moves; game FSM drives it in LOST and GREEN.
- enable_count_last_i  in  1  exit timer enable, from the game FSM.
- pos_x_o  out  XW  current column.
- pos_y_o  out  YW  current row.
- steps_left_o  out  SW  remaining steps.
- move_ack_o  out  1  one-cycle pulse when a move is accepted.
- bump_o  out  1  one-cycle pulse when a move is rejected at a grid edge.
- in_key_pos_o  out  1  position equals the key cell.
- in_exit_pos_o  out  1  position equals the exit cell.
- out_of_steps_o  out  1  steps_left_o == 0.
- timeout_15s_o  out  1  exit timer expired.

## Operation

- Input path: each button passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3). A held button produces exactly one request.
- Arbitration: one move per cycle, fixed priority up > down > left > right. Lower-priority edges in the same cycle are discarded, not queued.
- Direction convention: up = y-1, down = y+1, left = x-1, right = x+1.
- Accept conditions: a request is accepted when freeze_i = 0, steps_left_o != 0, and the target cell lies inside the grid.
  - On accept: update the position, decrement steps_left_o by 1, pulse move_ack_o.
- Edge rejection: a request whose target lies outside the grid (y = 0 up, y = GRID_H-1 down, x = 0 left, x = GRID_W-1 right) pulses bump_o. Position and steps are unchanged.
- Other rejections: requests while frozen or with zero steps have no effect and pulse neither move_ack_o nor bump_o.
- Status flags: in_key_pos_o, in_exit_pos_o and out_of_steps_o are decoded combinationally from the position and step registers. in_exit_pos_o does not depend on key ownership; the game FSM handles that.
- Exit timer:
  - 30-bit counter cleared whenever enable_count_last_i = 0 and incremented while it is 1.
  - When the count reaches TIMEOUT_CYCLES-1, timeout_15s_o is registered high and the counter holds.
  - timeout_15s_o stays high until enable_count_last_i falls, then clears on the next clock.
- Reset (asynchronous, any time, including mid-move or mid-timer):
  - position = (START_X, START_Y), steps_left_o = MAX_STEPS.
  - Synchronizers, edge detectors and timer counter = 0.
  - move_ack_o = bump_o = timeout_15s_o = 0.
  - in_key_pos_o and in_exit_pos_o follow the start position; out_of_steps_o = 0 when MAX_STEPS > 0.

## Timing

- Move latency: a button level first sampled at clock edge N sets sync2 at N+1. The position, steps and move_ack_o/bump_o update at edge N+2. The status flags change in the same cycle as the position.
- move_ack_o and bump_o are registered and last exactly one cycle.
- Last step: the step counter reaches 0 on the accepting edge, out_of_steps_o rises in that cycle, and further requests are ignored.
- A single move can both land on the key cell and exhaust the steps. In that case in_key_pos_o and out_of_steps_o are high in the same cycle; the game FSM gives the key priority.
- Timer: with enable high from edge E, timeout_15s_o rises at edge E + TIMEOUT_CYCLES. It clears one clock after enable_count_last_i falls.
- Release of rst_async_la_i is synchronous to clk_50MHz_i; no edge is detected from buttons already held during reset.

## Test plan

1. Reset then four right presses, with defaults: pos goes (0,0) to (4,0), steps_left_o 32 to 28, four move_ack_o pulses, each 3 clocks after the press.
2. Press left at (0,0): bump_o pulses once, pos stays (0,0), steps stay 32. Hold up and right together: only up is evaluated and bumps; right is dropped.
3. Walk to (5,2): in_key_pos_o high in the same cycle as the pos update. Walk on to (7,7): in_exit_pos_o high and in_key_pos_o low.
4. With MAX_STEPS=3: three accepted moves drive out_of_steps_o high. A fourth press gives no move_ack_o, no bump_o and no pos change.
5. With TIMEOUT_CYCLES=20: enable high for 25 cycles gives timeout_15s_o rising exactly 20 clocks after enable. Dropping enable at cycle 10 and re-raising it restarts the count from 0.
6. Assert rst_async_la_i low mid-move and mid-timer: all outputs return to reset values without waiting for a clock. freeze_i = 1 blocks all presses.
